gerenciador_de_ataque_n: RTL

// - Parametrised, fully synchronous successor of the battleship attack manager.
// - Latches the secret map at game start and takes one shot per confirmar press at (coordColuna, coordLinha).
// - Reveals hits on the LED-matrix image, drives the hit/miss/repeat status LEDs and owns the lives counter.
// - Declares victory or defeat. Sits between the coordinate-input logic and the LED-matrix driver.

---
 rtl/batalha_naval_pkg.sv | 28 ++
 rtl/contador_vida_n.sv | 28 ++
 rtl/gerenciador_de_ataque_n.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/batalha_naval_pkg.sv
// Shared definitions for the battleship attack manager.
//   estado_t : game FSM states
//   led_t    : status LED word, packed as {R, G, B}
//   idx()    : flat bit position of grid cell (c, r) in mapa/matriz
package batalha_naval_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        AGUARDA,
        AVALIA,
        VITORIA,
        DERROTA
    } estado_t;

    typedef logic [2:0] led_t;

    localparam led_t LED_APAGADO = 3'b000;  // all off
    localparam led_t LED_ERRO    = 3'b100;  // red: miss
    localparam led_t LED_ACERTO  = 3'b010;  // green: hit
    localparam led_t LED_AVISO   = 3'b001;  // blue: invalid or repeated shot

    // Column-major cell numbering: a column occupies num_rows consecutive bits.
    function automatic int unsigned idx(input int unsigned c, input int unsigned r,
                                        input int unsigned num_rows);
        return c * num_rows + r;
    endfunction

endpackage

// File: rtl/contador_vida_n.sv
// Lives counter for the attack manager.
//   clock       : rising-edge clock
//   reset       : synchronous, active-high; loads VIDAS
//   carregar    : synchronous load of VIDAS (new game / game cleared)
//   decrementar : take one life; saturates at zero, never wraps
//   vida        : remaining lives
module contador_vida_n #(
    parameter int VIDAS  = 3,
    parameter int VIDA_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              carregar,
    input  logic              decrementar,
    output logic [VIDA_W-1:0] vida
);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values and simulation matches the synthesized netlist.
    always_ff @(posedge clock) begin
        if (reset || carregar) begin
            vida <= VIDA_W'(VIDAS);
        end else if (decrementar && (vida != '0)) begin
            vida <= vida - 1'b1;
        end
    end

endmodule

// File: rtl/gerenciador_de_ataque_n.sv
// Battleship attack manager. Latches the secret map when the game is enabled, takes one
// shot per rising edge of confirmar, reveals hits on matriz, drives the status LEDs,
// owns the lives counter and declares victory or defeat.
//
// Ports:
//   clock, reset        : single clock; synchronous active-high reset
//   enable              : game active; low clears the whole game on any edge
//   confirmar           : shot button (level); rising edge detected internally
//   coordColuna/Linha   : target cell
//   mapa                : ship map, bit c*NUM_ROWS+r = ship at (c, r)
//   matriz              : revealed hits, same indexing
//   LED_R/LED_G/LED_B   : miss / hit / invalid-or-repeat status, held until next shot
//   vida                : remaining lives
//   vitoria, derrota    : game won / lives exhausted
//
// Build option: define ATAQUE_REPETIDO_EN to keep a miss register (tiros_q) and flag shots
// on already-hit or already-missed cells with LED_B instead of charging a life.
module gerenciador_de_ataque_n
    import batalha_naval_pkg::*;
#(
    parameter int NUM_COLS = 5,
    parameter int NUM_ROWS = 7,
    parameter int COL_W    = 3,
    parameter int ROW_W    = 3,
    parameter int VIDAS    = 3,
    parameter int VIDA_W   = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         confirmar,
    input  logic [COL_W-1:0]             coordColuna,
    input  logic [ROW_W-1:0]             coordLinha,
    input  logic [NUM_COLS*NUM_ROWS-1:0] mapa,
    output logic [NUM_COLS*NUM_ROWS-1:0] matriz,
    output logic                         LED_R,
    output logic                         LED_G,
    output logic                         LED_B,
    output logic [VIDA_W-1:0]            vida,
    output logic                         vitoria,
    output logic                         derrota
);

    localparam int CELLS = NUM_COLS * NUM_ROWS;
    localparam int POS_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    estado_t            estado_q, estado_d;
    logic [CELLS-1:0]   mapa_q;
    logic [CELLS-1:0]   matriz_q, matriz_d;
    led_t               leds_q, leds_d;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   lin_q;
    // confirmar_s is an input stage; the edge is detected between it and confirmar_q,
    // which places the shot result two edges after confirmar is first sampled high.
    logic               confirmar_s, confirmar_q;
    logic               borda;
    logic               limpar;
    logic               valido;
    logic               acerto;
    logic               repetido;
    logic               decrementar;
    logic [POS_W-1:0]   pos;
    logic [VIDA_W-1:0]  vida_apos;
`ifdef ATAQUE_REPETIDO_EN
    logic [CELLS-1:0]   tiros_q, tiros_d;
`endif

    assign limpar = reset || !enable;
    assign borda  = confirmar_s && !confirmar_q;
    assign valido = (int'(col_q) < NUM_COLS) && (int'(lin_q) < NUM_ROWS);
    assign pos    = POS_W'(idx(int'(col_q), int'(lin_q), NUM_ROWS));
    // Classification terms are only meaningful when valido; out-of-range pos is never used.
    assign acerto = valido && mapa_q[pos] && !matriz_q[pos];
`ifdef ATAQUE_REPETIDO_EN
    assign repetido = valido && (matriz_q[pos] || tiros_q[pos]);
`else
    assign repetido = 1'b0;
`endif
    assign vida_apos = (vida == '0) ? '0 : vida - 1'b1;

    // NOTE: every signal driven here gets a default before the case statement, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        estado_d    = estado_q;
        matriz_d    = matriz_q;
        leds_d      = leds_q;
        decrementar = 1'b0;
`ifdef ATAQUE_REPETIDO_EN
        tiros_d     = tiros_q;
`endif
        case (estado_q)
            OCIOSO: begin
                if (enable) begin
                    estado_d = AGUARDA;
                    leds_d   = LED_APAGADO;
                end
            end
            AGUARDA: begin
                if (borda) begin
                    estado_d = AVALIA;
                end
            end
            AVALIA: begin
                if (!valido) begin
                    leds_d   = LED_AVISO;
                    estado_d = AGUARDA;
                end else begin
                    if (acerto) begin
                        matriz_d[pos] = 1'b1;
                        leds_d        = LED_ACERTO;
                    end else if (repetido) begin
                        leds_d = LED_AVISO;
                    end else begin
                        leds_d      = LED_ERRO;
                        decrementar = 1'b1;
`ifdef ATAQUE_REPETIDO_EN
                        tiros_d[pos] = 1'b1;
`endif
                    end
                    // Victory is tested first; a hit never costs a life, so both cannot hold.
                    if ((matriz_d & mapa_q) == mapa_q) begin
                        estado_d = VITORIA;
                    end else if (decrementar && (vida_apos == '0)) begin
                        estado_d = DERROTA;
                    end else begin
                        estado_d = AGUARDA;
                    end
                end
            end
            default: begin
                // VITORIA / DERROTA hold until enable drops or reset.
                estado_d = estado_q;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (limpar) begin
            estado_q    <= OCIOSO;
            mapa_q      <= '0;
            matriz_q    <= '0;
            leds_q      <= LED_APAGADO;
            col_q       <= '0;
            lin_q       <= '0;
            confirmar_s <= 1'b0;
            confirmar_q <= 1'b0;
`ifdef ATAQUE_REPETIDO_EN
            tiros_q     <= '0;
`endif
        end else begin
            estado_q    <= estado_d;
            matriz_q    <= matriz_d;
            leds_q      <= leds_d;
            confirmar_s <= confirmar;
            confirmar_q <= confirmar_s;
`ifdef ATAQUE_REPETIDO_EN
            tiros_q     <= tiros_d;
`endif
            // The map is captured once per game; later changes on mapa are ignored.
            if (estado_q == OCIOSO) begin
                mapa_q <= mapa;
            end
            if ((estado_q == AGUARDA) && borda) begin
                col_q <= coordColuna;
                lin_q <= coordLinha;
            end
        end
    end

    contador_vida_n #(
        .VIDAS  (VIDAS),
        .VIDA_W (VIDA_W)
    ) u_contador_vida (
        .clock       (clock),
        .reset       (reset),
        .carregar    (!enable || (estado_q == OCIOSO)),
        .decrementar (decrementar),
        .vida        (vida)
    );

    assign matriz  = matriz_q;
    assign LED_R   = leds_q[2];
    assign LED_G   = leds_q[1];
    assign LED_B   = leds_q[0];
    assign vitoria = (estado_q == VITORIA);
    assign derrota = (estado_q == DERROTA);

endmodule
